// File: rtl/capture_seq_if.sv
// rtl/capture_seq_if.sv - sample-in / capture-out stream bundle for capture_seq
interface capture_seq_if #(
  parameter int size = 32
);
  logic [size-1:0] s_tdata;
  logic            s_tvalid;
  logic [size-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/capture_seq.sv
// rtl/capture_seq.sv - multi-stage trigger sequencer with pre/post window and stream output
module capture_seq #(
  parameter int size    = 32,
  parameter int levels  = 8,
  parameter int saddr_w = 24,
  parameter int cnt_w   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          abort,
  capture_seq_if.slave                  bus,
  input  logic [levels*size-1:0]        trig_mask,
  input  logic [levels*size-1:0]        trig_type,
  input  logic [levels*size-1:0]        trig_level,
  input  logic [levels*cnt_w-1:0]       trig_count,
  input  logic [$clog2(levels+1)-1:0]   levels_used,
  input  logic [saddr_w-1:0]            buffer_size,
  input  logic [saddr_w-1:0]            post_trigger_count,
  output logic                          triggered,
  output logic                          done,
  output logic                          overrun,
  output logic [$clog2(levels+1)-1:0]   stage,
  output logic [saddr_w-1:0]            trigger_pos
);
  localparam int sw = $clog2(levels + 1);
  localparam logic [sw-1:0] lv_max = sw'(levels);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t state_q, state_d;

  logic [saddr_w-1:0] wr_addr, pre_cnt, post_cnt;
  logic [cnt_w-1:0]   occ;
  logic [size-1:0]    prev_data;
  logic               prev_valid;

  logic               active, go_abort, go_arm, acc_ok, drop;
  logic [sw-1:0]      lu_eff;
  logic [saddr_w-1:0] post_eff, pre_len, wr_next;
  logic               eval;
  int                 sel_i;
  logic [size-1:0]    cur_mask, cur_type, cur_level;
  logic [cnt_w-1:0]   cur_need, need_eff;
  logic [size-1:0]    lvl_ok, edge_ok, bit_ok;
  logic               stage_hit, stage_done, trig_fire, last_fire;

  always_comb begin
    active   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    go_abort = abort && active;
    go_arm   = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    acc_ok   = active && !abort && bus.s_tvalid && (!bus.m_tvalid || bus.m_tready);
    drop     = active && bus.s_tvalid && bus.m_tvalid && !bus.m_tready;

    lu_eff = (levels_used > lv_max) ? lv_max : levels_used;
    if (post_trigger_count == '0)
      post_eff = saddr_w'(1);
    else if (post_trigger_count > buffer_size)
      post_eff = buffer_size;
    else
      post_eff = post_trigger_count;
    pre_len = buffer_size - post_eff;
    wr_next = (wr_addr == buffer_size - saddr_w'(1)) ? '0 : wr_addr + saddr_w'(1);
  end

  // Stage index is only meaningful while below lu_eff; elsewhere slot 0 keeps the select in range.
  always_comb begin
    eval      = (state_q == S_WAIT) && (stage < lu_eff);
    sel_i     = eval ? int'(stage) : 0;
    cur_mask  = trig_mask[sel_i*size +: size];
    cur_type  = trig_type[sel_i*size +: size];
    cur_level = trig_level[sel_i*size +: size];
    cur_need  = trig_count[sel_i*cnt_w +: cnt_w];
    need_eff  = (cur_need == '0) ? cnt_w'(1) : cur_need;

    lvl_ok     = ~(bus.s_tdata ^ cur_level);
    edge_ok    = lvl_ok & (prev_data ^ bus.s_tdata) & {size{prev_valid}};
    bit_ok     = (cur_type & edge_ok) | (~cur_type & lvl_ok);
    stage_hit  = &(bit_ok | ~cur_mask);
    stage_done = stage_hit && (occ + cnt_w'(1) == need_eff);

    trig_fire = acc_ok && (state_q == S_WAIT) &&
                ((lu_eff == '0) || (eval && stage_done && (stage + sw'(1) == lu_eff)));
    last_fire = (trig_fire && (post_eff == saddr_w'(1))) ||
                (acc_ok && (state_q == S_POST) && (post_cnt + saddr_w'(1) == post_eff));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (go_arm) state_d = (pre_len == '0) ? S_WAIT : S_PRE;
      S_PRE: begin
        if (go_abort) state_d = S_IDLE;
        else if (acc_ok && (pre_cnt + saddr_w'(1) == pre_len)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (go_abort) state_d = S_IDLE;
        else if (trig_fire) state_d = last_fire ? S_DONE : S_POST;
      end
      S_POST: begin
        if (go_abort) state_d = S_IDLE;
        else if (last_fire) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bus.m_tdata  <= '0;
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      triggered    <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      stage        <= '0;
      trigger_pos  <= '0;
      wr_addr      <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      occ          <= '0;
      prev_data    <= '0;
      prev_valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_DONE) && (state_d == S_DONE);
      if (go_arm) begin
        triggered  <= 1'b0;
        overrun    <= 1'b0;
        stage      <= '0;
        wr_addr    <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        occ        <= '0;
        prev_valid <= 1'b0;
      end
      if (go_abort) begin
        triggered    <= 1'b0;
        bus.m_tvalid <= 1'b0;
        bus.m_tlast  <= 1'b0;
      end else begin
        if (drop) overrun <= 1'b1;
        if (acc_ok) begin
          bus.m_tdata  <= bus.s_tdata;
          bus.m_tvalid <= 1'b1;
          bus.m_tlast  <= last_fire;
          prev_data    <= bus.s_tdata;
          prev_valid   <= 1'b1;
          wr_addr      <= wr_next;
          if (state_q == S_PRE) pre_cnt <= pre_cnt + saddr_w'(1);
          if (state_q == S_POST) post_cnt <= post_cnt + saddr_w'(1);
          if (eval && stage_hit) begin
            if (stage_done) begin
              occ   <= '0;
              stage <= stage + sw'(1);
            end else begin
              occ <= occ + cnt_w'(1);
            end
          end
          if (trig_fire) begin
            trigger_pos <= wr_addr;
            triggered   <= 1'b1;
            post_cnt    <= saddr_w'(1);
          end
        end else if (bus.m_tready) begin
          bus.m_tvalid <= 1'b0;
          bus.m_tlast  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_capture_seq.sv
// tb/tb_capture_seq.sv - self-checking bench for capture_seq against an array-scan capture model
module tb_capture_seq;
  localparam int size = 32, levels = 8, saddr_w = 24, cnt_w = 16, sw = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, arm = 1'b0, abort = 1'b0;
  capture_seq_if #(.size(size)) bus();
  logic [levels*size-1:0]  trig_mask, trig_type, trig_level;
  logic [levels*cnt_w-1:0] trig_count;
  logic [sw-1:0]           levels_used;
  logic [saddr_w-1:0]      buffer_size, post_trigger_count;
  logic                    triggered, done, overrun;
  logic [sw-1:0]           stage;
  logic [saddr_w-1:0]      trigger_pos;

  capture_seq #(.size(size), .levels(levels), .saddr_w(saddr_w), .cnt_w(cnt_w)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .bus(bus),
    .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
    .trig_count(trig_count), .levels_used(levels_used), .buffer_size(buffer_size),
    .post_trigger_count(post_trigger_count), .triggered(triggered), .done(done),
    .overrun(overrun), .stage(stage), .trigger_pos(trigger_pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: capture = list of accepted samples; trigger found by scanning that list.
  int          ph = 0;
  bit          sf = 0, sl = 0, m_trig = 0, m_over = 0, m_done = 0;
  logic [31:0] sd = '0;
  int          m_stage = 0, m_tpos = 0;
  logic [31:0] q[$];

  function automatic int post_eff_f();
    int p, b;
    p = int'(post_trigger_count);
    b = int'(buffer_size);
    if (p == 0) p = 1;
    if (p > b) p = b;
    return p;
  endfunction

  function automatic void scan(output int t, output int s);
    int pre, lu, occ, need;
    logic [31:0] cur, prv, mk, ty, lv;
    bit hit;
    t = -1; s = 0; occ = 0;
    lu  = (int'(levels_used) > levels) ? levels : int'(levels_used);
    pre = int'(buffer_size) - post_eff_f();
    for (int i = pre; i < q.size(); i++) begin
      if (lu == 0) begin t = i; return; end
      cur = q[i];
      prv = (i > 0) ? q[i-1] : '0;
      mk = trig_mask[s*size +: size];
      ty = trig_type[s*size +: size];
      lv = trig_level[s*size +: size];
      need = (trig_count[s*cnt_w +: cnt_w] == 0) ? 1 : int'(trig_count[s*cnt_w +: cnt_w]);
      hit = 1'b1;
      for (int b = 0; b < size; b++) begin
        if (mk[b]) begin
          if (cur[b] != lv[b]) hit = 1'b0;
          else if (ty[b] && !(i > 0 && prv[b] != cur[b])) hit = 1'b0;
        end
      end
      if (hit) begin
        occ++;
        if (occ == need) begin
          occ = 0;
          s++;
          if (s == lu) begin t = i; return; end
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    int old_ph, t, s;
    bit was_full;
    old_ph = ph;
    if (reset) begin
      ph = 0; sf = 0; sl = 0; sd = '0; m_trig = 0; m_over = 0; m_stage = 0; m_tpos = 0;
      q.delete();
    end else if (abort && ph == 1) begin
      ph = 0; sf = 0; sl = 0; m_trig = 0;
    end else begin
      was_full = sf;
      if (sf && bus.m_tready) begin sf = 0; sl = 0; end
      if (ph == 1 && bus.s_tvalid) begin
        if (!was_full || bus.m_tready) begin
          q.push_back(bus.s_tdata);
          sf = 1; sd = bus.s_tdata; sl = 0;
          scan(t, s);
          m_stage = s;
          if (t >= 0) begin
            m_trig = 1;
            m_tpos = t % int'(buffer_size);
            if (q.size() == t + post_eff_f()) begin sl = 1; ph = 2; end
          end
        end else begin
          m_over = 1;
        end
      end
      if (arm && !abort && old_ph != 1) begin
        ph = 1; q.delete(); m_trig = 0; m_over = 0; m_stage = 0;
      end
    end
    m_done = (old_ph == 2) && (ph == 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tvalid", bus.m_tvalid, sf);
      if (sf) begin
        chk("m_tdata", bus.m_tdata, sd);
        chk("m_tlast", bus.m_tlast, sl);
      end
      chk("triggered", triggered, m_trig);
      chk("done", done, m_done);
      chk("overrun", overrun, m_over);
      chk("stage", stage, 64'(m_stage));
      chk("trigger_pos", trigger_pos, 64'(m_tpos));
    end
  end

  int          beats = 0, last_idx = 0;
  logic [31:0] beat_data [0:255];
  always @(posedge clk) begin
    if (!reset && bus.m_tvalid && bus.m_tready) begin
      if (beats < 256) beat_data[beats] = bus.m_tdata;
      beats++;
      if (bus.m_tlast) last_idx = beats;
    end
  end

  logic [31:0] t2d [0:14] = '{32'h00, 32'h01, 32'h00, 32'h01, 32'h00, 32'h11, 32'h10, 32'h01,
                              32'h00, 32'h11, 32'h01, 32'h10, 32'h20, 32'h21, 32'h22};
  logic [31:0] t5d [0:7]  = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h1, 32'h3, 32'h5, 32'h7};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cfg();
    trig_mask = '0; trig_type = '0; trig_level = '0; trig_count = '0; levels_used = '0;
  endtask

  task automatic set_stage(input int k, input logic [31:0] mk, input logic [31:0] ty,
                           input logic [31:0] lv, input int cnt);
    trig_mask[k*size +: size]   = mk;
    trig_type[k*size +: size]   = ty;
    trig_level[k*size +: size]  = lv;
    trig_count[k*cnt_w +: cnt_w] = cnt_w'(cnt);
  endtask

  task automatic start_capture();
    beats = 0; last_idx = 0;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic stream_until_done(input logic [31:0] start, input int budget);
    logic [31:0] v;
    v = start;
    for (int n = 0; n < budget && !done; n++) begin
      bus.s_tdata = v; bus.s_tvalid = 1'b1;
      step();
      v++;
    end
    bus.s_tvalid = 1'b0;
    step(); step();
    chk("done_reached", done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.m_tready = 1'b1;
    clr_cfg();
    buffer_size = 24'd16; post_trigger_count = 24'd8;
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_tvalid", bus.m_tvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_stage", stage, 0);

    // all-pass trigger, 128 ring with 64 post samples
    clr_cfg(); levels_used = 4'd1;
    buffer_size = 24'd128; post_trigger_count = 24'd64;
    start_capture();
    stream_until_done(32'd0, 400);
    chk("t1_trigger_pos", trigger_pos, 64);
    chk("t1_model_tpos", 64'(m_tpos), 64);
    chk("t1_beats", 64'(beats), 128);
    chk("t1_last_idx", 64'(last_idx), 128);
    chk("t1_last_data", beat_data[127], 127);
    chk("t1_trig_data", beat_data[64], 64);
    chk("t1_overrun", overrun, 0);

    // edge stage (3 rising bit0) then level stage (bit4=1)
    clr_cfg();
    set_stage(0, 32'h1, 32'h1, 32'h1, 3);
    set_stage(1, 32'h10, 32'h0, 32'h10, 1);
    levels_used = 4'd2; buffer_size = 24'd8; post_trigger_count = 24'd4;
    start_capture();
    for (int i = 0; i < 15; i++) begin
      bus.s_tdata = t2d[i]; bus.s_tvalid = 1'b1;
      step();
      if (i == 8)  chk("t2_stage_at8", stage, 0);
      if (i == 9)  chk("t2_stage_at9", stage, 1);
      if (i == 11) chk("t2_stage_at11", stage, 2);
    end
    bus.s_tvalid = 1'b0;
    step(); step();
    chk("t2_done", done, 1);
    chk("t2_trigger_pos", trigger_pos, 3);
    chk("t2_beats", 64'(beats), 15);
    chk("t2_last_idx", 64'(last_idx), 15);
    chk("t2_trig_data", beat_data[11], 32'h10);
    chk("t2_last_data", beat_data[14], 32'h22);

    // back-pressure: register takes one, two dropped
    clr_cfg(); levels_used = 4'd1;
    buffer_size = 24'd16; post_trigger_count = 24'd8;
    start_capture();
    bus.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_tdata = 32'h100 + i; bus.s_tvalid = 1'b1;
      step();
    end
    chk("t3_overrun_early", overrun, 1);
    bus.m_tready = 1'b1;
    stream_until_done(32'h103, 100);
    chk("t3_overrun_sticky", overrun, 1);
    chk("t3_beats", 64'(beats), 16);
    chk("t3_beat0", beat_data[0], 32'h100);
    chk("t3_beat1", beat_data[1], 32'h103);
    chk("t3_trigger_pos", trigger_pos, 8);
    chk("t3_last_data", beat_data[15], 32'h111);

    // no stages, no pre region
    clr_cfg(); levels_used = 4'd0;
    buffer_size = 24'd8; post_trigger_count = 24'd8;
    start_capture();
    stream_until_done(32'h200, 50);
    chk("t4a_trigger_pos", trigger_pos, 0);
    chk("t4a_beats", 64'(beats), 8);
    chk("t4a_last_idx", 64'(last_idx), 8);
    chk("t4a_beat0", beat_data[0], 32'h200);
    buffer_size = 24'd5; post_trigger_count = 24'd3;
    start_capture();
    stream_until_done(32'h300, 50);
    chk("t4b_trigger_pos", trigger_pos, 2);
    chk("t4b_beats", 64'(beats), 5);
    chk("t4b_trig_data", beat_data[2], 32'h302);
    // late trigger forces the ring address through zero
    levels_used = 4'd1;
    set_stage(0, 32'h8, 32'h0, 32'h8, 2);
    start_capture();
    stream_until_done(32'h400, 60);
    chk("t4c_trigger_pos", trigger_pos, 4);
    chk("t4c_beats", 64'(beats), 12);
    chk("t4c_trig_data", beat_data[9], 32'h409);

    // abort + arm together in WAIT
    clr_cfg(); levels_used = 4'd1;
    set_stage(0, 32'h1, 32'h0, 32'h1, 1);
    buffer_size = 24'd8; post_trigger_count = 24'd4;
    start_capture();
    for (int i = 0; i < 6; i++) begin
      bus.s_tdata = 32'(2 * i); bus.s_tvalid = 1'b1;
      step();
    end
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    step();
    chk("t5_tvalid_idle", bus.m_tvalid, 0);
    chk("t5_done", done, 0);
    chk("t5_trig", triggered, 0);
    step();
    chk("t5_no_accept", bus.m_tvalid, 0);
    bus.s_tvalid = 1'b0;
    start_capture();
    chk("t5_stage_rearm", stage, 0);
    for (int i = 0; i < 8; i++) begin
      bus.s_tdata = t5d[i]; bus.s_tvalid = 1'b1;
      step();
    end
    bus.s_tvalid = 1'b0;
    step(); step();
    chk("t5_done_after", done, 1);
    chk("t5_trigger_pos", trigger_pos, 4);
    chk("t5_beats", 64'(beats), 8);

    // reset during POST, then post count 0 acts as 1
    clr_cfg(); levels_used = 4'd1;
    buffer_size = 24'd16; post_trigger_count = 24'd8;
    start_capture();
    for (int i = 0; i < 10; i++) begin
      bus.s_tdata = 32'(i); bus.s_tvalid = 1'b1;
      step();
    end
    chk("t6_trig_before", triggered, 1);
    reset = 1'b1;
    step();
    reset = 1'b0; bus.s_tvalid = 1'b0;
    chk("t6_rst_tvalid", bus.m_tvalid, 0);
    chk("t6_rst_trig", triggered, 0);
    chk("t6_rst_tpos", trigger_pos, 0);
    chk("t6_rst_stage", stage, 0);
    chk("t6_rst_done", done, 0);
    step();
    buffer_size = 24'd4; post_trigger_count = 24'd0;
    start_capture();
    stream_until_done(32'h500, 40);
    chk("t6_trigger_pos", trigger_pos, 3);
    chk("t6_beats", 64'(beats), 4);
    chk("t6_last_idx", 64'(last_idx), 4);
    chk("t6_last_data", beat_data[3], 32'h503);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
